// File: rtl/pyjamask_pkg.sv
// Shared types and helpers for the two-requester Pyjamask-96 scheduler.
// Byte indexing everywhere is MSB first: byte 0 is the top byte of the vector.
package pyjamask_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_COLLECT,
    S_RESP,
    S_RECOVER
  } state_t;

  localparam int PT_BYTES  = 12;
  localparam int KEY_BYTES = 16;
  localparam int PT_W      = 8 * PT_BYTES;
  localparam int KEY_W     = 8 * KEY_BYTES;

  // vec holds an nbytes-wide value right-aligned; indices past the end read as zero
  function automatic logic [7:0] msb_byte(input logic [KEY_W-1:0] vec,
                                          input int nbytes, input int idx);
    logic [KEY_W-1:0] sh;
    logic [7:0]       b;
    b  = 8'h00;
    sh = '0;
    if (idx < nbytes) begin
      sh = vec >> (8 * (nbytes - 1 - idx));
      b  = sh[7:0];
    end
    return b;
  endfunction

endpackage

// File: rtl/pyjamask96_sched_if.sv
// Requester-side bundle: two request ports sharing one tagged response channel.
interface pyjamask96_sched_if;
  import pyjamask_pkg::*;

  logic             req0;
  logic             req1;
  logic [PT_W-1:0]  pt0;
  logic [PT_W-1:0]  pt1;
  logic [KEY_W-1:0] key0;
  logic [KEY_W-1:0] key1;
  logic             resp_valid;
  logic             resp_id;
  logic             resp_err;
  logic [PT_W-1:0]  resp_ct;
  logic             busy;

  modport master (
    output req0, req1, pt0, pt1, key0, key1,
    input  resp_valid, resp_id, resp_err, resp_ct, busy
  );

  modport slave (
    input  req0, req1, pt0, pt1, key0, key1,
    output resp_valid, resp_id, resp_err, resp_ct, busy
  );
endinterface

// File: rtl/pyjamask96_rr_arb.sv
// Two-way round-robin arbiter; the winner of a tie is whoever was not served last.
module pyjamask96_rr_arb (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic upd_en,
  input  logic upd_id,
  output logic gnt_any,
  output logic gnt_id
);

  logic last_id;

  assign gnt_any = req0 | req1;
  assign gnt_id  = (req0 && req1) ? ~last_id : req1;

  // Reset value 1 lets requester 0 win the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last_id <= 1'b1;
    else if (upd_en) last_id <= upd_id;
  end

endmodule

// File: rtl/pyjamask96_sched.sv
// Shares one byte-serial Pyjamask-96 core between two requesters: serialises
// plaintext/key in, reassembles ciphertext out, and resets the core on a stall.
module pyjamask96_sched
  import pyjamask_pkg::*;
#(
  parameter int TIMEOUT    = 64,
  parameter int RST_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  pyjamask96_sched_if.slave    bus,
  output logic                 core_load,
  output logic                 core_start,
  output logic [7:0]           core_byte_in,
  output logic [7:0]           core_byte_key_in,
  output logic                 core_reset_n,
  input  logic                 core_valid,
  input  logic [7:0]           core_byte_out
);

  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam int RCNT_W = $clog2(RST_CYCLES + 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);
  localparam logic [RCNT_W-1:0] RST_LAST  = RCNT_W'(RST_CYCLES - 1);
  localparam logic [3:0]        LOAD_LAST = 4'(KEY_BYTES - 1);
  localparam logic [3:0]        CT_LAST   = 4'(PT_BYTES - 1);

  state_t             state, nxt_state;
  logic [3:0]         byte_cnt, nxt_byte_cnt;
  logic [3:0]         k_cnt, nxt_k_cnt;
  logic [WCNT_W-1:0]  wcnt, nxt_wcnt;
  logic [RCNT_W-1:0]  rcnt, nxt_rcnt;
  logic               gnt, nxt_gnt;
  logic [PT_W-1:0]    pt_q, nxt_pt;
  logic [KEY_W-1:0]   key_q, nxt_key;
  logic [PT_W-1:0]    ct_buf, nxt_ct_buf;

  logic               resp_valid, nxt_resp_valid;
  logic               resp_id, nxt_resp_id;
  logic               resp_err, nxt_resp_err;
  logic [PT_W-1:0]    resp_ct, nxt_resp_ct;
  logic               busy, nxt_busy;
  logic               nxt_load, nxt_start, nxt_reset_n;
  logic [7:0]         nxt_byte_in, nxt_key_in;

  logic               arb_any, arb_id;
  logic [PT_W-1:0]    sel_pt;
  logic [KEY_W-1:0]   sel_key;

  pyjamask96_rr_arb u_arb (
    .clk     (clk),
    .reset   (reset),
    .req0    (bus.req0),
    .req1    (bus.req1),
    .upd_en  (state == S_RESP),
    .upd_id  (gnt),
    .gnt_any (arb_any),
    .gnt_id  (arb_id)
  );

  assign sel_pt  = arb_id ? bus.pt1  : bus.pt0;
  assign sel_key = arb_id ? bus.key1 : bus.key0;

  assign bus.resp_valid = resp_valid;
  assign bus.resp_id    = resp_id;
  assign bus.resp_err   = resp_err;
  assign bus.resp_ct    = resp_ct;
  assign bus.busy       = busy;

  always_comb begin
    nxt_state      = state;
    nxt_byte_cnt   = byte_cnt;
    nxt_k_cnt      = k_cnt;
    nxt_wcnt       = wcnt;
    nxt_rcnt       = rcnt;
    nxt_gnt        = gnt;
    nxt_pt         = pt_q;
    nxt_key        = key_q;
    nxt_ct_buf     = ct_buf;
    nxt_resp_valid = 1'b0;
    nxt_resp_id    = resp_id;
    nxt_resp_err   = resp_err;
    nxt_resp_ct    = resp_ct;
    nxt_load       = 1'b0;
    nxt_start      = 1'b0;
    nxt_byte_in    = 8'h00;
    nxt_key_in     = 8'h00;
    nxt_reset_n    = 1'b1;

    case (state)
      S_IDLE: begin
        if (arb_any) begin
          // Byte 0 is presented straight from the requester so LOAD starts next cycle
          nxt_gnt      = arb_id;
          nxt_pt       = sel_pt;
          nxt_key      = sel_key;
          nxt_byte_cnt = 4'd0;
          nxt_state    = S_LOAD;
          nxt_load     = 1'b1;
          nxt_byte_in  = msb_byte({32'h0, sel_pt}, PT_BYTES, 0);
          nxt_key_in   = msb_byte(sel_key, KEY_BYTES, 0);
        end
      end
      S_LOAD: begin
        if (byte_cnt == LOAD_LAST) begin
          nxt_state = S_START;
          nxt_start = 1'b1;
        end else begin
          nxt_byte_cnt = byte_cnt + 4'd1;
          nxt_byte_in  = msb_byte({32'h0, pt_q}, PT_BYTES, int'(byte_cnt) + 1);
          nxt_key_in   = msb_byte(key_q, KEY_BYTES, int'(byte_cnt) + 1);
        end
      end
      S_START: begin
        nxt_state = S_WAIT;
        nxt_wcnt  = '0;
      end
      S_WAIT, S_COLLECT: begin
        if (core_valid) begin
          nxt_wcnt = '0;
          if (state == S_WAIT) begin
            nxt_ct_buf       = '0;
            nxt_ct_buf[7:0]  = core_byte_out;
            nxt_k_cnt        = 4'd1;
            nxt_state        = S_COLLECT;
          end else begin
            nxt_ct_buf[8*k_cnt +: 8] = core_byte_out;
            if (k_cnt == CT_LAST) begin
              nxt_state      = S_RESP;
              nxt_resp_valid = 1'b1;
              nxt_resp_id    = gnt;
              nxt_resp_err   = 1'b0;
              nxt_resp_ct    = nxt_ct_buf;
            end else begin
              nxt_k_cnt = k_cnt + 4'd1;
            end
          end
        end else if (wcnt == WAIT_LAST) begin
          nxt_state   = S_RECOVER;
          nxt_rcnt    = '0;
          nxt_reset_n = 1'b0;
        end else begin
          nxt_wcnt = wcnt + 1'b1;
        end
      end
      S_RECOVER: begin
        if (rcnt == RST_LAST) begin
          nxt_state      = S_RESP;
          nxt_resp_valid = 1'b1;
          nxt_resp_id    = gnt;
          nxt_resp_err   = 1'b1;
          nxt_resp_ct    = '0;
        end else begin
          nxt_rcnt    = rcnt + 1'b1;
          nxt_reset_n = 1'b0;
        end
      end
      S_RESP: begin
        nxt_state = S_IDLE;
      end
      default: nxt_state = S_IDLE;
    endcase

    nxt_busy = (nxt_state != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      byte_cnt         <= '0;
      k_cnt            <= '0;
      wcnt             <= '0;
      rcnt             <= '0;
      gnt              <= 1'b0;
      pt_q             <= '0;
      key_q            <= '0;
      ct_buf           <= '0;
      resp_valid       <= 1'b0;
      resp_id          <= 1'b0;
      resp_err         <= 1'b0;
      resp_ct          <= '0;
      busy             <= 1'b0;
      core_load        <= 1'b0;
      core_start       <= 1'b0;
      core_byte_in     <= 8'h00;
      core_byte_key_in <= 8'h00;
      core_reset_n     <= 1'b1;
    end else begin
      state            <= nxt_state;
      byte_cnt         <= nxt_byte_cnt;
      k_cnt            <= nxt_k_cnt;
      wcnt             <= nxt_wcnt;
      rcnt             <= nxt_rcnt;
      gnt              <= nxt_gnt;
      pt_q             <= nxt_pt;
      key_q            <= nxt_key;
      ct_buf           <= nxt_ct_buf;
      resp_valid       <= nxt_resp_valid;
      resp_id          <= nxt_resp_id;
      resp_err         <= nxt_resp_err;
      resp_ct          <= nxt_resp_ct;
      busy             <= nxt_busy;
      core_load        <= nxt_load;
      core_start       <= nxt_start;
      core_byte_in     <= nxt_byte_in;
      core_byte_key_in <= nxt_key_in;
      core_reset_n     <= nxt_reset_n;
    end
  end

endmodule

// File: tb/tb_pyjamask96_sched.sv
// Directed bench for pyjamask96_sched with a toy core model that returns
// ct byte j = pt byte j ^ key byte j ^ 8'h5a from the bytes it was loaded with.
module tb_pyjamask96_sched;

  localparam int TIMEOUT    = 64;
  localparam int RST_CYCLES = 2;

  localparam logic [95:0]  PT_A  = 96'h0123456789abcdef01234567;
  localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [95:0]  PT_B  = 96'hfedcba9876543210a5a5c3c3;
  localparam logic [127:0] KEY_B = 128'hffeeddccbbaa99887766554433221100;

  logic       clk = 1'b0;
  logic       reset;
  logic       core_load, core_start, core_reset_n;
  logic [7:0] core_byte_in, core_byte_key_in;
  logic       core_valid;
  logic [7:0] core_byte_out;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] cap_pt  [16];
  logic [7:0] cap_key [16];

  pyjamask96_sched_if bus ();

  pyjamask96_sched #(.TIMEOUT(TIMEOUT), .RST_CYCLES(RST_CYCLES)) dut (
    .clk              (clk),
    .reset            (reset),
    .bus              (bus),
    .core_load        (core_load),
    .core_start       (core_start),
    .core_byte_in     (core_byte_in),
    .core_byte_key_in (core_byte_key_in),
    .core_reset_n     (core_reset_n),
    .core_valid       (core_valid),
    .core_byte_out    (core_byte_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] ref_ct(input logic [95:0] pt, input logic [127:0] key);
    logic [95:0] r;
    for (int j = 0; j < 12; j++)
      r[8*j +: 8] = pt[95-8*j -: 8] ^ key[127-8*j -: 8] ^ 8'h5a;
    return r;
  endfunction

  // Captures the 16 load bytes; returns positioned on the START cycle.
  task automatic load_phase(input string tag);
    int waited = 0;
    while (core_load !== 1'b1 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_load_seen"}, 128'(core_load), 128'(1'b1));
    for (int i = 0; i < 16; i++) begin
      if (i == 1) chk({tag, "_load_pulse"}, 128'(core_load), 128'(1'b0));
      cap_pt[i]  = core_byte_in;
      cap_key[i] = core_byte_key_in;
      @(negedge clk);
    end
    chk({tag, "_start"}, 128'(core_start), 128'(1'b1));
  endtask

  task automatic core_reply(input int lat, input int gap, input int nbytes);
    core_valid = 1'b0;
    repeat (lat) @(negedge clk);
    for (int j = 0; j < nbytes; j++) begin
      core_valid    = 1'b1;
      core_byte_out = cap_pt[j] ^ cap_key[j] ^ 8'h5a;
      @(negedge clk);
      if (gap > 0 && j < nbytes - 1) begin
        core_valid    = 1'b0;
        core_byte_out = 8'hee;
        repeat (gap) @(negedge clk);
      end
    end
    core_valid    = 1'b0;
    core_byte_out = 8'h00;
  endtask

  task automatic wait_resp(input string tag, input int limit, output int cyc);
    cyc = 0;
    while (resp_seen() !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_resp_seen"}, 128'(bus.resp_valid), 128'(1'b1));
  endtask

  function automatic logic resp_seen();
    return bus.resp_valid;
  endfunction

  task automatic finish_txn(input string tag, input logic exp_id, input logic [95:0] exp_ct,
                            input bit keep0, input bit keep1);
    chk({tag, "_id"},  128'(bus.resp_id),  128'(exp_id));
    chk({tag, "_err"}, 128'(bus.resp_err), 128'(1'b0));
    chk({tag, "_ct"},  128'(bus.resp_ct),  128'(exp_ct));
    if (!keep0) bus.req0 = 1'b0;
    if (!keep1) bus.req1 = 1'b0;
    @(negedge clk);
    chk({tag, "_strobe_1cyc"}, 128'(bus.resp_valid), 128'(1'b0));
    chk({tag, "_idle"},        128'(bus.busy),       128'(1'b0));
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    int seen;
    logic exp_id;

    reset         = 1'b1;
    bus.req0      = 1'b0;
    bus.req1      = 1'b0;
    bus.pt0       = '0;
    bus.pt1       = '0;
    bus.key0      = '0;
    bus.key1      = '0;
    core_valid    = 1'b0;
    core_byte_out = 8'h00;
    repeat (2) @(negedge clk);

    chk("rst_busy",       128'(bus.busy),         128'(1'b0));
    chk("rst_resp_valid", 128'(bus.resp_valid),   128'(1'b0));
    chk("rst_resp_id",    128'(bus.resp_id),      128'(1'b0));
    chk("rst_resp_err",   128'(bus.resp_err),     128'(1'b0));
    chk("rst_resp_ct",    128'(bus.resp_ct),      128'(0));
    chk("rst_load",       128'(core_load),        128'(1'b0));
    chk("rst_start",      128'(core_start),       128'(1'b0));
    chk("rst_byte_in",    128'(core_byte_in),     128'(8'h00));
    chk("rst_key_in",     128'(core_byte_key_in), 128'(8'h00));
    chk("rst_core_rstn",  128'(core_reset_n),     128'(1'b1));
    reset = 1'b0;
    @(negedge clk);

    // single request from requester 0
    bus.pt0  = PT_A;
    bus.key0 = KEY_A;
    bus.pt1  = PT_B;
    bus.key1 = KEY_B;
    bus.req0 = 1'b1;
    @(negedge clk);
    chk("t1_grant_latency", 128'(core_load), 128'(1'b1));
    load_phase("t1");
    chk("t1_first_pt",   128'(cap_pt[0]),   128'(8'h01));
    chk("t1_first_key",  128'(cap_key[0]),  128'(8'h00));
    chk("t1_pt11",       128'(cap_pt[11]),  128'(8'h67));
    chk("t1_last_key",   128'(cap_key[15]), 128'(8'h0f));
    chk("t1_last_pt",    128'(cap_pt[15]),  128'(8'h00));
    chk("t1_busy",       128'(bus.busy),    128'(1'b1));
    core_reply(3, 0, 12);
    wait_resp("t1", 200, cyc);
    chk("t1_resp_after_last_byte", 128'(cyc), 128'(0));
    finish_txn("t1", 1'b0, ref_ct(PT_A, KEY_A), 1'b0, 1'b0);

    // simultaneous requests from reset: 0 then 1
    pulse_reset();
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    load_phase("t2a");
    core_reply(2, 0, 12);
    wait_resp("t2a", 200, cyc);
    finish_txn("t2a", 1'b0, ref_ct(PT_A, KEY_A), 1'b0, 1'b1);
    load_phase("t2b");
    core_reply(2, 0, 12);
    wait_resp("t2b", 200, cyc);
    finish_txn("t2b", 1'b1, ref_ct(PT_B, KEY_B), 1'b0, 1'b0);

    // both held for four transactions: 0,1,0,1
    pulse_reset();
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    for (int t = 0; t < 4; t++) begin
      exp_id = t[0];
      load_phase($sformatf("t3_%0d", t));
      core_reply(1, 0, 12);
      wait_resp($sformatf("t3_%0d", t), 200, cyc);
      finish_txn($sformatf("t3_%0d", t), exp_id,
                 exp_id ? ref_ct(PT_B, KEY_B) : ref_ct(PT_A, KEY_A), t < 3, t < 3);
    end

    // core never answers: timeout in WAIT
    bus.req0 = 1'b1;
    load_phase("t4");
    cyc = 0;
    while (core_reset_n !== 1'b0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("t4_wait_len", 128'(cyc), 128'(TIMEOUT + 1));
    @(negedge clk);
    chk("t4_rstn_2nd",    128'(core_reset_n),   128'(1'b0));
    @(negedge clk);
    chk("t4_rstn_release",128'(core_reset_n),   128'(1'b1));
    chk("t4_resp_valid",  128'(bus.resp_valid), 128'(1'b1));
    chk("t4_resp_err",    128'(bus.resp_err),   128'(1'b1));
    chk("t4_resp_ct",     128'(bus.resp_ct),    128'(0));
    chk("t4_resp_id",     128'(bus.resp_id),    128'(1'b0));
    bus.req0 = 1'b0;
    @(negedge clk);
    chk("t4_idle", 128'(bus.busy), 128'(1'b0));

    // 5-cycle gaps between bytes; stray valid in IDLE/LOAD ignored
    core_valid    = 1'b1;
    core_byte_out = 8'hff;
    bus.req1      = 1'b1;
    load_phase("t5");
    core_reply(2, 5, 12);
    wait_resp("t5", 10, cyc);
    finish_txn("t5", 1'b1, ref_ct(PT_B, KEY_B), 1'b0, 1'b0);

    // gap of TIMEOUT cycles after three bytes
    bus.req0 = 1'b1;
    load_phase("t6");
    core_reply(2, 0, 3);
    wait_resp("t6", 200, cyc);
    chk("t6_gap_len", 128'(cyc),          128'(TIMEOUT + 2));
    chk("t6_err",     128'(bus.resp_err), 128'(1'b1));
    chk("t6_ct",      128'(bus.resp_ct),  128'(0));
    chk("t6_id",      128'(bus.resp_id),  128'(1'b0));
    bus.req0 = 1'b0;
    @(negedge clk);

    // reset during COLLECT at k=6
    bus.req0 = 1'b1;
    load_phase("t7");
    core_reply(2, 0, 6);
    chk("t7_busy_before", 128'(bus.busy), 128'(1'b1));
    reset = 1'b1;
    #1;
    chk("t7_busy",       128'(bus.busy),       128'(1'b0));
    chk("t7_resp_valid", 128'(bus.resp_valid), 128'(1'b0));
    chk("t7_resp_err",   128'(bus.resp_err),   128'(1'b0));
    chk("t7_resp_ct",    128'(bus.resp_ct),    128'(0));
    chk("t7_core_rstn",  128'(core_reset_n),   128'(1'b1));
    chk("t7_load",       128'(core_load),      128'(1'b0));
    bus.req0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) seen++;
    end
    chk("t7_no_resp", 128'(seen), 128'(0));
    bus.req1 = 1'b1;
    load_phase("t7b");
    core_reply(4, 0, 12);
    wait_resp("t7b", 200, cyc);
    finish_txn("t7b", 1'b1, ref_ct(PT_B, KEY_B), 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pyjamask96_sched.md
# pyjamask96_sched

Round-robin scheduler that shares one byte-serial Pyjamask-96 encryption core between two requesters. It accepts a parallel 96-bit plaintext and 128-bit key from the granted requester, serialises them into the core, and waits for the core's serial ciphertext. It reassembles that ciphertext into a 96-bit result tagged with the requester id, and recovers the core via a timeout-driven reset if it stalls.

## Interface
- TIMEOUT, 64: max cycles spent in WAIT, or between consecutive valid bytes in COLLECT, before abort.
- RST_CYCLES, 2: cycles core_reset_n is held low after a timeout.
- clk  in  1  single clock, all logic posedge.
- reset  in  1  asynchronous, active-high; clears every register immediately.
- req0, req1  in  1 each  request; held high until the matching resp_valid.
- pt0, pt1  in  96 each  plaintext; stable while req high.
- key0, key1  in  128 each  key; stable while req high.
- resp_valid  out  1  one-cycle result strobe.
- resp_id  out  1  requester served (0/1).
- resp_err  out  1  1 = timeout abort; resp_ct invalid.
- resp_ct  out  96  ciphertext.
- busy  out  1  high in every state except IDLE.
- core_load  out  1  to core load.
- core_start  out  1  to core start.
- core_byte_in  out  8  to core byte_in.
- core_byte_key_in  out  8  to core byte_key_in.
- core_reset_n  out  1  to core reset, active-low.
- core_valid  in  1  from core valid.
- core_byte_out  in  8  from core byte_out.

## Operation
- States: IDLE, LOAD, START, WAIT, COLLECT, RESP, RECOVER.
- IDLE: when any req is high, grant and latch pt/key into internal registers. Go to LOAD with byte_cnt=0.
  - Only one requester high: grant it.
  - Both high: grant the one not served last. last_id resets to 1, so requester 0 wins the first tie.
- LOAD, 16 cycles, byte_cnt 0..15:
  - core_load=1 only at byte_cnt=0.
  - core_byte_key_in = key byte byte_cnt, MSB first (byte 0 = key[127:120]).
  - core_byte_in = pt byte byte_cnt, MSB first (byte 0 = pt[95:88]) for byte_cnt<=11; 8'h00 for 12..15.
- START: core_start=1 for one cycle, then WAIT.
- WAIT: on core_valid go to COLLECT, capturing that byte as byte 0.
- COLLECT: each valid cycle stores core_byte_out into resp_ct[8*k+7:8*k], k=0..11; the first byte received is the LSB.
  - core_valid low mid-collect: hold and restart the gap counter.
  - After k=11: go to RESP.
- RESP: resp_valid=1, resp_id=grant, resp_err=0; last_id<=grant; then IDLE.
- Timeout: wait counter (width clog2(TIMEOUT+1)) reaches TIMEOUT in WAIT or COLLECT.
  - Go to RECOVER: core_reset_n=0 for RST_CYCLES.
  - Then a one-cycle RESP with resp_err=1, resp_ct=0; last_id updated; then IDLE.
- A requester dropping req after grant is ignored; the transaction completes and its response is still issued.
- A req rising while busy is recorded only at the next IDLE arbitration.
- core_valid in IDLE/LOAD/START: ignored.

## Timing
- Reset values: resp_valid=0, resp_id=0, resp_err=0, resp_ct=0, busy=0, core_load=0, core_start=0, core_byte_in=0, core_byte_key_in=0, core_reset_n=1; state=IDLE, last_id=1.
- All outputs are registered.
- req sampled in IDLE → first LOAD cycle next cycle.
- core_start occurs 17 cycles after grant.
- Request-to-resp_valid latency: 1+16+1+core latency+12+1 cycles with contiguous valid.
- Back-to-back service: after RESP, IDLE samples req the following cycle; minimum one IDLE cycle between transactions.
- reset mid-transaction: immediate return to IDLE; no response issued; core_reset_n=1 (the core shares system reset).

## Structure
- Shared package pyjamask_pkg holds:
  - state enum;
  - PT_BYTES=12, KEY_BYTES=16;
  - byte-select helper for MSB-first indexing.
- One natural sub-module: pyjamask96_rr_arb (two-way round-robin grant with last_id register).
- Serialiser/collector stay inline.

## Test plan
- Single request: req0, pt=96'h0123456789abcdef01234567, key=128'h000102…0f. Required response:
  - core sees load with byte_in=8'h01, key_in=8'h00;
  - 16th byte_key_in=8'h0f with byte_in=8'h00;
  - start on the following cycle;
  - model core returns bytes → resp_ct matches the reference model, resp_id=0.
- Simultaneous req0 and req1 from reset → requester 0 served first, then requester 1; resp_id sequence 0,1.
- Both held continuously for 4 transactions → resp_id alternates 0,1,0,1.
- Core never asserts valid → after TIMEOUT cycles in WAIT:
  - core_reset_n low exactly 2 cycles;
  - resp_valid with resp_err=1, resp_ct=0.
- Core valid gaps of 5 cycles between bytes → correct resp_ct, no timeout. A gap of TIMEOUT cycles → err response.
- reset asserted during COLLECT (k=6) → all outputs at reset values the same cycle; no resp_valid. The next req completes normally.
